// File: rtl/key_scan_encoder_pkg.sv
// -----------------------------------------------------------------------------
// key_scan_encoder_pkg
// Shared definitions for the key scan encoder: FSM state encodings, the
// "no key" code, the number of scanned keys and the priority encoder that
// turns a vector of press events into a key code.
// -----------------------------------------------------------------------------
package key_scan_encoder_pkg;

    localparam int NUM_KEYS = 3;

    // FSM state encodings (binary)
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REPORT   = 2'd1;
    localparam logic [1:0] ST_WAIT_REL = 2'd2;

    // Key_Out value before any press has been accepted
    localparam logic [1:0] KEY_NONE = 2'd0;

    // Lowest index wins: Key_In[0] -> 1, Key_In[1] -> 2, Key_In[2] -> 3.
    function automatic logic [1:0] key_code(input logic [NUM_KEYS-1:0] rise);
        logic [1:0] code;
        code = KEY_NONE;
        if (rise[0]) begin
            code = 2'd1;
        end else if (rise[1]) begin
            code = 2'd2;
        end else if (rise[2]) begin
            code = 2'd3;
        end
        return code;
    endfunction

endpackage

// File: rtl/key_scan_encoder_if.sv
// -----------------------------------------------------------------------------
// key_scan_encoder_if
// Bundles the key front end's functional signals.
//   EN         enable for accepting new presses   (master -> slave)
//   Key_In     raw buttons, asynchronous          (master -> slave)
//   Key_Out    code of last accepted key          (slave  -> master)
//   Key_Strobe one-cycle pulse on a new Key_Out   (slave  -> master)
//   Key_Busy   press reported, not yet released  (slave  -> master)
// The encoder uses the slave modport; the button/board side uses master.
// -----------------------------------------------------------------------------
interface key_scan_encoder_if;
    import key_scan_encoder_pkg::*;

    logic                EN;
    logic [NUM_KEYS-1:0] Key_In;
    logic [1:0]          Key_Out;
    logic                Key_Strobe;
    logic                Key_Busy;

    modport master (
        output EN,
        output Key_In,
        input  Key_Out,
        input  Key_Strobe,
        input  Key_Busy
    );

    modport slave (
        input  EN,
        input  Key_In,
        output Key_Out,
        output Key_Strobe,
        output Key_Busy
    );

endinterface

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One button: 2-flop synchroniser, polarity normalisation, tick-driven
// debounce counter, debounced level and a one-cycle press event.
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous reset, active-low
//   tick    one-cycle sample strobe from the shared prescaler
//   raw     raw button level, asynchronous to clk
//   stable  debounced level, 1 = pressed
//   rise    one-cycle pulse when stable goes from released to pressed
// -----------------------------------------------------------------------------
module key_debounce
    import key_scan_encoder_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int              CNT_W    = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic            RAW_IDLE = (KEY_ACTIVE_LOW != 0);

    logic [1:0]       sync;
    logic             pressed;
    logic [CNT_W-1:0] cnt;

    // Synchroniser resets to the released raw level so that coming out of
    // reset does not look like a pending change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {2{RAW_IDLE}};
        end else begin
            sync <= {sync[0], raw};
        end
    end

    assign pressed = sync[1] ^ RAW_IDLE;

    // cnt counts consecutive ticks on which the sampled level disagreed with
    // stable; the DEBOUNCE_TICKS-th disagreeing sample commits the change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (tick) begin
                if (pressed != stable) begin
                    if (cnt == CNT_TC) begin
                        stable <= pressed;
                        cnt    <= '0;
                        rise   <= pressed;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/key_scan_encoder.sv
// -----------------------------------------------------------------------------
// key_scan_encoder
// Key front end for the nixie tube driver. Debounces three raw buttons and
// reports each newly accepted press once as a held 2-bit code plus a
// one-cycle strobe; no auto-repeat.
// Ports:
//   Sys_CLK   system clock, rising edge
//   Sys_RST   asynchronous reset, active-low
//   kbus      key_scan_encoder_if.slave:
//               EN, Key_In (inputs); Key_Out, Key_Strobe, Key_Busy (outputs)
// -----------------------------------------------------------------------------
module key_scan_encoder
    import key_scan_encoder_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int TICK_HZ        = 1000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic                Sys_CLK,
    input  logic                Sys_RST,
    key_scan_encoder_if.slave   kbus
);

    localparam int               DIV   = CLK_HZ / TICK_HZ;
    localparam int               PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(DIV - 1);

    logic [PRE_W-1:0]    prescaler;
    logic                tick;
    logic [NUM_KEYS-1:0] stable;
    logic [NUM_KEYS-1:0] rise;
    logic [1:0]          state;
    logic [1:0]          key_out;

    // Debounce sample-rate prescaler
    always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            prescaler <= '0;
        end else if (prescaler == PRE_TC) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    assign tick = (prescaler == PRE_TC);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_debounce (
            .clk    (Sys_CLK),
            .rst_n  (Sys_RST),
            .tick   (tick),
            .raw    (kbus.Key_In[i]),
            .stable (stable[i]),
            .rise   (rise[i])
        );
    end

    // Report FSM. Press events are only looked at in IDLE, so anything that
    // rises while a press is being reported or held is dropped for good.
    always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            state   <= ST_IDLE;
            key_out <= KEY_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (kbus.EN && (|rise)) begin
                        state   <= ST_REPORT;
                        key_out <= key_code(rise);
                    end
                end
                ST_REPORT: begin
                    state <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    // Wait for every key, not just the reported one, so a
                    // second key held alongside cannot be reported later.
                    if (stable == '0) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign kbus.Key_Out    = key_out;
    assign kbus.Key_Strobe = (state == ST_REPORT);
    assign kbus.Key_Busy   = (state == ST_WAIT_REL);

endmodule

// File: tb/tb_key_scan_encoder.sv
// -----------------------------------------------------------------------------
// tb_key_scan_encoder
// Directed bench for key_scan_encoder with a 10-clock debounce tick and
// four-sample debounce. Buttons are active-low (raw 1 = released).
// -----------------------------------------------------------------------------
module tb_key_scan_encoder;
    import key_scan_encoder_pkg::*;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DB      = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks       = 0;
    int errors       = 0;
    int cyc          = 0;
    int strobe_total = 0;

    always #5 clk = ~clk;

    key_scan_encoder_if kbus ();

    key_scan_encoder #(
        .CLK_HZ         (CLK_HZ),
        .TICK_HZ        (TICK_HZ),
        .DEBOUNCE_TICKS (DB),
        .KEY_ACTIVE_LOW (1)
    ) dut (
        .Sys_CLK (clk),
        .Sys_RST (rst_n),
        .kbus    (kbus)
    );

    // Edge index since reset release, used to place presses at a known
    // phase of the 10-clock sample period.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (kbus.Key_Strobe) strobe_total <= strobe_total + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int i);
        kbus.Key_In[i] = 1'b0;
    endtask

    task automatic release_key(input int i);
        kbus.Key_In[i] = 1'b1;
    endtask

    task automatic wait_strobe(input int max, output int lat, output int seen);
        lat  = 0;
        seen = 0;
        while (lat < max && seen == 0) begin
            @(posedge clk);
            #1;
            lat++;
            if (kbus.Key_Strobe) seen = 1;
        end
    endtask

    task automatic wait_busy_low(input int max, output int lat, output int seen);
        lat  = 0;
        seen = 0;
        while (lat < max && seen == 0) begin
            @(posedge clk);
            #1;
            lat++;
            if (!kbus.Key_Busy) seen = 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int seen;
        int base;
        int bad;

        kbus.EN     = 1'b1;
        kbus.Key_In = 3'b111;

        // 1: reset and idle
        rst_n = 1'b0;
        step(5);
        chk("t1_rst_key_out", int'(kbus.Key_Out), 0);
        chk("t1_rst_strobe", int'(kbus.Key_Strobe), 0);
        chk("t1_rst_busy", int'(kbus.Key_Busy), 0);
        rst_n = 1'b1;
        bad = 0;
        for (int n = 0; n < 200; n++) begin
            step(1);
            if (kbus.Key_Out != 2'd0 || kbus.Key_Strobe || kbus.Key_Busy) bad++;
        end
        chk("t1_idle_quiet", bad, 0);

        // 2: single press of key 1, released after 100 clocks.
        // Press just after an edge index = 8 (mod 10): four samples at the
        // following 10-clock ticks give a strobe 43 clocks after the press.
        while (cyc % 10 != 8) step(1);
        base = strobe_total;
        press(1);
        wait_strobe(60, lat, seen);
        chk("t2_strobe_seen", seen, 1);
        chk("t2_strobe_window", int'(lat >= 42 && lat <= 52), 1);
        chk("t2_key_out", int'(kbus.Key_Out), 2);
        step(100 - lat);
        chk("t2_busy_held", int'(kbus.Key_Busy), 1);
        release_key(1);
        wait_busy_low(60, lat, seen);
        chk("t2_busy_fall_seen", seen, 1);
        chk("t2_busy_fall_window", int'(lat >= 40 && lat <= 50), 1);
        step(20);
        chk("t2_one_strobe", strobe_total - base, 1);

        // 3: bouncing key 0, then a lone 25-clock pulse
        base = strobe_total;
        for (int n = 0; n < 5; n++) begin
            press(0);
            step(3);
            release_key(0);
            step(3);
        end
        press(0);
        wait_strobe(100, lat, seen);
        chk("t3_strobe_seen", seen, 1);
        chk("t3_key_out", int'(kbus.Key_Out), 1);
        step(30);
        chk("t3_one_strobe", strobe_total - base, 1);
        release_key(0);
        wait_busy_low(100, lat, seen);
        chk("t3_released", seen, 1);
        base = strobe_total;
        press(0);
        step(25);
        release_key(0);
        step(80);
        chk("t3_short_pulse_strobes", strobe_total - base, 0);
        chk("t3_short_pulse_busy", int'(kbus.Key_Busy), 0);

        // 4: keys 2 and 0 together
        base = strobe_total;
        press(2);
        press(0);
        wait_strobe(100, lat, seen);
        chk("t4_strobe_seen", seen, 1);
        chk("t4_key_out", int'(kbus.Key_Out), 1);
        release_key(0);
        step(80);
        chk("t4_busy_key2_held", int'(kbus.Key_Busy), 1);
        release_key(2);
        wait_busy_low(100, lat, seen);
        chk("t4_busy_released", seen, 1);
        step(20);
        chk("t4_one_strobe", strobe_total - base, 1);
        chk("t4_key_out_held", int'(kbus.Key_Out), 1);

        // 5: press while disabled, enable while still held
        kbus.EN = 1'b0;
        base = strobe_total;
        press(2);
        step(80);
        chk("t5_dis_strobes", strobe_total - base, 0);
        chk("t5_dis_key_out", int'(kbus.Key_Out), 1);
        kbus.EN = 1'b1;
        step(80);
        chk("t5_en_held_strobes", strobe_total - base, 0);
        chk("t5_en_held_busy", int'(kbus.Key_Busy), 0);
        release_key(2);
        step(80);
        press(2);
        wait_strobe(100, lat, seen);
        chk("t5_repress_strobe", seen, 1);
        chk("t5_repress_key_out", int'(kbus.Key_Out), 3);
        release_key(2);
        wait_busy_low(100, lat, seen);
        chk("t5_released", seen, 1);

        // 6: reset during WAIT_REL with key 1 held
        press(1);
        wait_strobe(100, lat, seen);
        chk("t6_strobe_seen", seen, 1);
        chk("t6_key_out_before", int'(kbus.Key_Out), 2);
        step(10);
        chk("t6_busy_before", int'(kbus.Key_Busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_key_out", int'(kbus.Key_Out), 0);
        chk("t6_rst_busy", int'(kbus.Key_Busy), 0);
        chk("t6_rst_strobe", int'(kbus.Key_Strobe), 0);
        step(3);
        release_key(1);
        rst_n = 1'b1;
        base = strobe_total;
        step(80);
        chk("t6_after_rst_strobes", strobe_total - base, 0);
        chk("t6_after_rst_key_out", int'(kbus.Key_Out), 0);
        press(1);
        wait_strobe(100, lat, seen);
        chk("t6_repress_strobe", seen, 1);
        chk("t6_full_debounce", int'(lat >= 32 && lat <= 52), 1);
        chk("t6_repress_key_out", int'(kbus.Key_Out), 2);
        release_key(1);
        wait_busy_low(100, lat, seen);
        chk("t6_released", seen, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
